// File: rtl/lu_pkg.sv
// Shared definitions for the lu_pipe logic unit: op codes, op width and
// the output-stage state encoding.
package lu_pkg;

  localparam int LU_OP_W = 3;

  localparam logic [LU_OP_W-1:0] LU_AND   = 3'b000;
  localparam logic [LU_OP_W-1:0] LU_NAND  = 3'b001;
  localparam logic [LU_OP_W-1:0] LU_OR    = 3'b010;
  localparam logic [LU_OP_W-1:0] LU_NOR   = 3'b011;
  localparam logic [LU_OP_W-1:0] LU_XOR   = 3'b100;
  localparam logic [LU_OP_W-1:0] LU_XNOR  = 3'b101;
  localparam logic [LU_OP_W-1:0] LU_NOTA  = 3'b110;
  localparam logic [LU_OP_W-1:0] LU_PASSB = 3'b111;

  typedef enum logic {
    LU_EMPTY = 1'b0,
    LU_FULL  = 1'b1
  } lu_state_e;

endpackage

// File: rtl/lu_core.sv
// Purely combinational bitwise function unit: result = f(op, op_a, b).
module lu_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   b,
  input  logic [LU_OP_W-1:0] op,
  output logic [WIDTH-1:0]   result
);

  always_comb begin
    result = '0;
    case (op)
      LU_AND:   result = op_a & b;
      LU_NAND:  result = ~(op_a & b);
      LU_OR:    result = op_a | b;
      LU_NOR:   result = ~(op_a | b);
      LU_XOR:   result = op_a ^ b;
      LU_XNOR:  result = ~(op_a ^ b);
      LU_NOTA:  result = ~op_a;
      LU_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/lu_pipe.sv
// Registered logic unit with valid/ready output stage, accumulator and
// transfer counter. Define LU_FLAGS_EN to add registered zero/parity flags.
module lu_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [LU_OP_W-1:0] op,
  input  logic               acc_sel,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   s,
  output logic [WIDTH-1:0]   acc,
  output logic [CNT_W-1:0]   ops_done
`ifdef LU_FLAGS_EN
  ,
  output logic               zero,
  output logic               parity
`endif
);

  lu_state_e        state_p1, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] op_a, result;
  logic [WIDTH-1:0] s_p1, acc_p1;
  logic [CNT_W-1:0] cnt_p1;

  // The only combinational output path is out_ready -> in_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear on the same cycle as acc_sel forces operand A to zero.
  always_comb begin
    op_a = a;
    if (acc_sel) op_a = acc_clr ? '0 : acc_p1;
  end

  lu_core #(.WIDTH(WIDTH)) u_core (
    .op_a   (op_a),
    .b      (b),
    .op     (op),
    .result (result)
  );

  // ---- stage p1: output-stage state ----
  always_ff @(posedge clk) begin
    if (reset) state_p1 <= LU_EMPTY;
    else       state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      LU_EMPTY: if (accept) state_nxt = LU_FULL;
      LU_FULL:  if (!accept && out_ready) state_nxt = LU_EMPTY;
      default:  state_nxt = LU_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_p1 == LU_FULL);
  end

  // ---- stage p1: result, accumulator and counter registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      s_p1   <= '0;
      acc_p1 <= '0;
      cnt_p1 <= '0;
    end else begin
      if (accept) begin
        s_p1   <= result;
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
      if (accept)       acc_p1 <= result;
      else if (acc_clr) acc_p1 <= '0;
    end
  end

  assign s        = s_p1;
  assign acc      = acc_p1;
  assign ops_done = cnt_p1;

`ifdef LU_FLAGS_EN
  logic zero_p1, parity_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_p1   <= 1'b0;
      parity_p1 <= 1'b0;
    end else if (accept) begin
      zero_p1   <= (result == '0);
      parity_p1 <= ^result;
    end
  end

  assign zero   = zero_p1;
  assign parity = parity_p1;
`endif

endmodule

// File: tb/tb_lu_pipe.sv
// Self-checking bench for lu_pipe: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_lu_pipe;
  import lu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, acc_sel, acc_clr, out_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_ready, out_valid, in_ready2, out_valid2;
  logic [7:0] s, acc, s2, acc2, ops_done;
  logic [1:0] ops_done2;
`ifdef LU_FLAGS_EN
  logic       zero, parity, zero2, parity2;
`endif

  always #5 clk = ~clk;

  lu_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .acc(acc),
    .ops_done(ops_done)
`ifdef LU_FLAGS_EN
    , .zero(zero), .parity(parity)
`endif
  );

  lu_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .s(s2), .acc(acc2),
    .ops_done(ops_done2)
`ifdef LU_FLAGS_EN
    , .zero(zero2), .parity(parity2)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_s, m_acc;
  logic       m_vld, m_zero, m_par;
  int         m_cnt, m_cnt2;

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return ~(x & y);
      3'd2: return x | y;
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return y;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic iv, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [2:0] top, input logic as, input logic ac, input logic ordy);
    reset = rst; in_valid = iv; a = ta; b = tb_; op = top;
    acc_sel = as; acc_clr = ac; out_ready = ordy;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    logic [7:0] opa, r;
    logic       take;
    take = in_valid && (!m_vld || out_ready);
    if (reset) begin
      m_s = 0; m_acc = 0; m_vld = 0; m_cnt = 0; m_cnt2 = 0; m_zero = 0; m_par = 0;
    end else if (take) begin
      opa = acc_sel ? (acc_clr ? 8'h00 : m_acc) : a;
      r = ref_op(op, opa, b);
      m_s = r; m_acc = r; m_vld = 1;
      m_cnt = (m_cnt + 1) % 256;
      m_cnt2 = (m_cnt2 + 1) % 4;
      m_zero = (r == 0);
      m_par = ^r;
    end else begin
      if (out_ready) m_vld = 0;
      if (acc_clr) m_acc = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h want 00", s); end
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h want 00", acc); end
    checks++; if (ops_done !== 8'd0) begin errors++; $display("FAIL reset_ops_done: got %0d want 0", ops_done); end
`ifdef LU_FLAGS_EN
    checks++; if ({zero, parity} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {zero, parity}); end
`endif
  endtask

  task automatic test_basic();
    drive(0, 1, 8'hF0, 8'h3C, 3'd0, 0, 0, 1);
    tick();
    checks++; if (s !== 8'h30) begin errors++; $display("FAIL basic_s: got %h want 30", s); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    checks++; if (acc !== 8'h30) begin errors++; $display("FAIL basic_acc: got %h want 30", acc); end
    checks++; if (ops_done !== 8'd1) begin errors++; $display("FAIL basic_ops_done: got %0d want 1", ops_done); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_ops_sweep();
    logic [7:0] exp_s [8] = '{8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'h0F};
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'hA5, 8'h0F, 3'(i), 0, 0, 1);
      tick();
      checks++; if (s !== exp_s[i]) begin errors++; $display("FAIL sweep_op%0d: got %h want %h", i, s, exp_s[i]); end
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [7:0] hs, ha, hc;
    drive(0, 1, 8'h12, 8'h34, 3'd2, 0, 0, 1);
    tick();
    hs = s; ha = acc; hc = ops_done;
    checks++; if (hs !== 8'h36) begin errors++; $display("FAIL bp_first: got %h want 36", hs); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 0, 0);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
      tick();
      checks++; if ({out_valid, s, acc, ops_done} !== {1'b1, hs, ha, hc}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b s=%h acc=%h cnt=%0d want v=1 s=%h acc=%h cnt=%0d",
                           i, out_valid, s, acc, ops_done, hs, ha, hc);
      end
    end
    drive(0, 1, 8'h55, 8'h0F, 3'd0, 0, 0, 1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    tick();
    checks++; if ({s, ops_done} !== {8'h05, hc + 8'd1}) begin
      errors++; $display("FAIL bp_next: got s=%h cnt=%0d want s=05 cnt=%0d", s, ops_done, hc + 8'd1);
    end
    idle();
  endtask

  task automatic test_chain();
    drive(0, 1, 8'hFF, 8'h0F, 3'd4, 0, 0, 1);
    tick();
    checks++; if (acc !== 8'hF0) begin errors++; $display("FAIL chain_acc: got %h want F0", acc); end
    drive(0, 1, 8'h00, 8'h33, 3'd0, 1, 0, 1);
    tick();
    checks++; if (s !== 8'h30) begin errors++; $display("FAIL chain_and: got %h want 30", s); end
    drive(0, 1, 8'hAA, 8'h11, 3'd2, 1, 1, 1);
    tick();
    checks++; if (s !== 8'h11) begin errors++; $display("FAIL chain_clr_or: got %h want 11", s); end
    // clear while the output is stalled
    drive(0, 0, 8'h00, 8'h00, 3'd0, 0, 1, 0);
    tick();
    checks++; if ({acc, s, out_valid} !== {8'h00, 8'h11, 1'b1}) begin
      errors++; $display("FAIL chain_stalled_clr: got acc=%h s=%h v=%b want acc=00 s=11 v=1", acc, s, out_valid);
    end
    idle();
  endtask

  task automatic test_counter_wrap();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    drive(1, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'($urandom), 8'($urandom), 3'($urandom), 0, 0, 1);
      tick();
      checks++; if (ops_done2 !== seq[i]) begin errors++; $display("FAIL wrap%0d: got %0d want %0d", i, ops_done2, seq[i]); end
    end
    idle();
  endtask

  task automatic test_reset_full();
    drive(0, 1, 8'h3C, 8'hC3, 3'd2, 0, 0, 0);
    tick();
    drive(1, 1, 8'h11, 8'h22, 3'd2, 0, 0, 0);
    tick();
    checks++; if ({out_valid, s, acc, ops_done} !== {1'b0, 8'h00, 8'h00, 8'h00}) begin
      errors++; $display("FAIL reset_full: got v=%b s=%h acc=%h cnt=%0d want all 0", out_valid, s, acc, ops_done);
    end
    idle();
  endtask

`ifdef LU_FLAGS_EN
  task automatic test_flags();
    drive(0, 1, 8'h5A, 8'h5A, 3'd4, 0, 0, 1);
    tick();
    checks++; if ({zero, parity} !== 2'b10) begin errors++; $display("FAIL flags_eq: got z=%b p=%b want z=1 p=0", zero, parity); end
    drive(0, 1, 8'h07, 8'hFF, 3'd0, 0, 0, 1);
    tick();
    checks++; if ({zero, parity} !== 2'b01) begin errors++; $display("FAIL flags_07: got z=%b p=%b want z=0 p=1", zero, parity); end
    idle();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      #1;
      checks++; if (in_ready !== (!m_vld || out_ready)) begin
        errors++; $display("FAIL rand_in_ready@%0d: got %b want %b", i, in_ready, (!m_vld || out_ready));
      end
      tick();
      checks++; if ({out_valid, s, acc, ops_done, ops_done2} !== {m_vld, m_s, m_acc, 8'(m_cnt), 2'(m_cnt2)}) begin
        errors++; $display("FAIL rand_state@%0d: got v=%b s=%h acc=%h cnt=%0d cnt2=%0d want v=%b s=%h acc=%h cnt=%0d cnt2=%0d",
                           i, out_valid, s, acc, ops_done, ops_done2, m_vld, m_s, m_acc, m_cnt, m_cnt2);
      end
`ifdef LU_FLAGS_EN
      checks++; if ({zero, parity} !== {m_zero, m_par}) begin
        errors++; $display("FAIL rand_flags@%0d: got %b%b want %b%b", i, zero, parity, m_zero, m_par);
      end
`endif
    end
  endtask

  initial begin
    m_s = 0; m_acc = 0; m_vld = 0; m_cnt = 0; m_cnt2 = 0; m_zero = 0; m_par = 0;
    test_reset();
    test_basic();
    test_ops_sweep();
    test_backpressure();
    test_chain();
    test_counter_wrap();
    test_reset_full();
`ifdef LU_FLAGS_EN
    test_flags();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
